alarm_trigger: RTL and testbench

- Decides when the alarm sounds. Compares the BCD time read from the DS1302 RTC against a user-set alarm hour and minute.
- Drives the level signal `alarm` consumed directly by the alarm buzzer/LED stage.
- Implements arm/disarm, a ring timeout, snooze with a limited repeat count, and dismiss. All timing comes from an internal 1 s tick derived from the system clock.

---
 rtl/alarm_trigger.sv | 153 +++++++++++++++
 tb/tb_alarm_trigger.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_trigger.sv
// Alarm decision logic: compares the RTC time against the user alarm setting and
// sequences ringing, snooze and dismiss using an internal 1 s tick.
module alarm_trigger #(
    parameter int sys_clk_freq = 100_000_000,
    parameter int RING_SEC     = 60,
    parameter int SNOOZE_SEC   = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       time_valid,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic       alarm_en,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    output logic       alarm,
    output logic [1:0] state,
    output logic [3:0] snooze_cnt
);

    localparam int TICK_W = (sys_clk_freq > 1) ? $clog2(sys_clk_freq) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(sys_clk_freq - 1);
    localparam logic [15:0]       RING_LAST   = 16'(RING_SEC - 1);
    localparam logic [15:0]       SNOOZE_LAST = 16'(SNOOZE_SEC - 1);
    localparam logic [3:0]        SNOOZE_MAX  = 4'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        DISARMED = 2'b00,
        ARMED    = 2'b01,
        RINGING  = 2'b10,
        SNOOZE   = 2'b11
    } state_t;

    state_t            fsm;
    logic [TICK_W-1:0] tick_cnt;
    logic [15:0]       sec_cnt;
    logic              fired;

    logic tick;
    logic match;
    logic time_moved;
    logic ring_done;
    logic snooze_done;
    logic can_snooze;

    assign tick        = (tick_cnt == TICK_LAST);
    assign match       = time_valid && (cur_hour == set_hour) && (cur_min == set_min)
                         && (cur_sec == 8'h00);
    assign time_moved  = time_valid && ((cur_min != set_min) || (cur_hour != set_hour));
    assign ring_done   = tick && (sec_cnt == RING_LAST);
    assign snooze_done = tick && (sec_cnt == SNOOZE_LAST);
    assign can_snooze  = (snooze_cnt < SNOOZE_MAX);

    assign state = fsm;

    // Every state change also restarts the tick counter so the first second of a
    // state is a full second long; alarm is registered alongside the state.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            fsm        <= DISARMED;
            alarm      <= 1'b0;
            snooze_cnt <= 4'd0;
            tick_cnt   <= '0;
            sec_cnt    <= 16'd0;
            fired      <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            if (time_moved) begin
                fired <= 1'b0;
            end

            if (!alarm_en) begin
                if (fsm != DISARMED) begin
                    fsm      <= DISARMED;
                    tick_cnt <= '0;
                end
                alarm <= 1'b0;
            end else begin
                case (fsm)
                    DISARMED: begin
                        fsm      <= ARMED;
                        tick_cnt <= '0;
                    end

                    ARMED: begin
                        if (match && !fired) begin
                            fsm        <= RINGING;
                            alarm      <= 1'b1;
                            fired      <= 1'b1;
                            snooze_cnt <= 4'd0;
                            sec_cnt    <= 16'd0;
                            tick_cnt   <= '0;
                        end
                    end

                    RINGING: begin
                        if (btn_stop) begin
                            fsm      <= ARMED;
                            alarm    <= 1'b0;
                            tick_cnt <= '0;
                        end else if (btn_snooze) begin
                            // Once the snooze allowance is used up the button dismisses instead.
                            if (can_snooze) begin
                                fsm        <= SNOOZE;
                                snooze_cnt <= snooze_cnt + 4'd1;
                                sec_cnt    <= 16'd0;
                            end else begin
                                fsm <= ARMED;
                            end
                            alarm    <= 1'b0;
                            tick_cnt <= '0;
                        end else if (tick) begin
                            if (ring_done) begin
                                fsm      <= ARMED;
                                alarm    <= 1'b0;
                                tick_cnt <= '0;
                            end else begin
                                sec_cnt <= sec_cnt + 16'd1;
                            end
                        end
                    end

                    SNOOZE: begin
                        if (btn_stop) begin
                            fsm      <= ARMED;
                            tick_cnt <= '0;
                        end else if (tick) begin
                            if (snooze_done) begin
                                fsm      <= RINGING;
                                alarm    <= 1'b1;
                                sec_cnt  <= 16'd0;
                                tick_cnt <= '0;
                            end else begin
                                sec_cnt <= sec_cnt + 16'd1;
                            end
                        end
                    end

                    default: begin
                        fsm   <= DISARMED;
                        alarm <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: a vector table for single-cycle behaviour plus
// hand-written sequences for timeouts, snooze limits and asynchronous reset.
module tb_alarm_trigger;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       time_valid;
    logic [7:0] cur_hour;
    logic [7:0] cur_min;
    logic [7:0] cur_sec;
    logic [7:0] set_hour;
    logic [7:0] set_min;
    logic       alarm_en;
    logic       btn_stop;
    logic       btn_snooze;
    logic       alarm;
    logic [1:0] state;
    logic [3:0] snooze_cnt;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string      name;
        logic       tv;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic       en;
        logic       stop;
        logic       snz;
        logic       exp_alarm;
        logic [1:0] exp_state;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    alarm_trigger #(
        .sys_clk_freq(10),
        .RING_SEC(5),
        .SNOOZE_SEC(3),
        .MAX_SNOOZE(2)
    ) dut (
        .clk(clk),
        .reset_p(reset_p),
        .time_valid(time_valid),
        .cur_hour(cur_hour),
        .cur_min(cur_min),
        .cur_sec(cur_sec),
        .set_hour(set_hour),
        .set_min(set_min),
        .alarm_en(alarm_en),
        .btn_stop(btn_stop),
        .btn_snooze(btn_snooze),
        .alarm(alarm),
        .state(state),
        .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic add_vec(input string name, input logic tv, input logic [7:0] h,
                           input logic [7:0] m, input logic [7:0] s, input logic en,
                           input logic stop, input logic snz, input logic ea,
                           input logic [1:0] es, input logic [3:0] ec);
        vec_t v;
        v = '{name, tv, h, m, s, en, stop, snz, ea, es, ec};
        vecs.push_back(v);
    endtask

    // Inputs are driven 1 ns after a rising edge and held for exactly one edge.
    task automatic apply_stimulus(input logic tv, input logic [7:0] h, input logic [7:0] m,
                                  input logic [7:0] s, input logic en, input logic stop,
                                  input logic snz);
        time_valid = tv;
        cur_hour   = h;
        cur_min    = m;
        cur_sec    = s;
        alarm_en   = en;
        btn_stop   = stop;
        btn_snooze = snz;
        @(posedge clk);
        #1;
        time_valid = 1'b0;
        btn_stop   = 1'b0;
        btn_snooze = 1'b0;
    endtask

    task automatic check_output(input string name, input logic ea, input logic [1:0] es,
                                input logic [3:0] ec);
        vectors++;
        if (alarm !== ea || state !== es || snooze_cnt !== ec) begin
            miscompares++;
            $display("[TB] FAIL %s: got alarm=%0b state=%b snooze_cnt=%0d, expected alarm=%0b state=%b snooze_cnt=%0d",
                     name, alarm, state, snooze_cnt, ea, es, ec);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic tv, input logic [7:0] h,
                        input logic [7:0] m, input logic [7:0] s, input logic en,
                        input logic stop, input logic snz, input logic ea,
                        input logic [1:0] es, input logic [3:0] ec);
        apply_stimulus(tv, h, m, s, en, stop, snz);
        check_output(name, ea, es, ec);
    endtask

    initial begin
        reset_p    = 1'b1;
        time_valid = 1'b0;
        cur_hour   = 8'h00;
        cur_min    = 8'h00;
        cur_sec    = 8'h00;
        set_hour   = 8'h07;
        set_min    = 8'h30;
        alarm_en   = 1'b0;
        btn_stop   = 1'b0;
        btn_snooze = 1'b0;

        //       name                 tv  hour   min    sec    en stp snz  alm st     cnt
        add_vec("disarmed_idle",     0, 8'h00, 8'h00, 8'h00, 0, 0, 0,  0, 2'b00, 4'd0);
        add_vec("arm",               0, 8'h00, 8'h00, 8'h00, 1, 0, 0,  0, 2'b01, 4'd0);
        add_vec("pre_minute",        1, 8'h07, 8'h29, 8'h59, 1, 0, 0,  0, 2'b01, 4'd0);
        add_vec("trigger",           1, 8'h07, 8'h30, 8'h00, 1, 0, 0,  1, 2'b10, 4'd0);
        add_vec("stop",              0, 8'h07, 8'h30, 8'h00, 1, 1, 0,  0, 2'b01, 4'd0);
        add_vec("repeat_sec00",      1, 8'h07, 8'h30, 8'h00, 1, 0, 0,  0, 2'b01, 4'd0);
        add_vec("next_minute",       1, 8'h07, 8'h31, 8'h00, 1, 0, 0,  0, 2'b01, 4'd0);
        add_vec("retrigger",         1, 8'h07, 8'h30, 8'h00, 1, 0, 0,  1, 2'b10, 4'd0);
        add_vec("snooze1",           0, 8'h07, 8'h30, 8'h00, 1, 0, 1,  0, 2'b11, 4'd1);
        add_vec("snooze_in_snooze",  0, 8'h07, 8'h30, 8'h00, 1, 0, 1,  0, 2'b11, 4'd1);
        add_vec("stop_in_snooze",    0, 8'h07, 8'h30, 8'h00, 1, 1, 0,  0, 2'b01, 4'd1);
        add_vec("disarm",            0, 8'h07, 8'h30, 8'h00, 0, 0, 0,  0, 2'b00, 4'd1);
        add_vec("match_disarmed",    1, 8'h07, 8'h30, 8'h00, 0, 0, 0,  0, 2'b00, 4'd1);
        add_vec("rearm",             0, 8'h07, 8'h30, 8'h00, 1, 0, 0,  0, 2'b01, 4'd1);
        add_vec("fired_held",        1, 8'h07, 8'h30, 8'h00, 1, 0, 0,  0, 2'b01, 4'd1);
        add_vec("clear_fired",       1, 8'h07, 8'h32, 8'h00, 1, 0, 0,  0, 2'b01, 4'd1);
        add_vec("trigger2",          1, 8'h07, 8'h30, 8'h00, 1, 0, 0,  1, 2'b10, 4'd0);
        add_vec("stop_and_snooze",   0, 8'h07, 8'h30, 8'h00, 1, 1, 1,  0, 2'b01, 4'd0);
        add_vec("wrong_hour",        1, 8'h08, 8'h30, 8'h00, 1, 0, 0,  0, 2'b01, 4'd0);
        add_vec("sec_nonzero",       1, 8'h07, 8'h30, 8'h01, 1, 0, 0,  0, 2'b01, 4'd0);
        add_vec("no_strobe",         0, 8'h07, 8'h30, 8'h00, 1, 0, 0,  0, 2'b01, 4'd0);
        add_vec("trigger3",          1, 8'h07, 8'h30, 8'h00, 1, 0, 0,  1, 2'b10, 4'd0);
        add_vec("disarm_over_snz",   0, 8'h07, 8'h30, 8'h00, 0, 0, 1,  0, 2'b00, 4'd0);

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", 1'b0, 2'b00, 4'd0);
        reset_p = 1'b0;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].tv, vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].en,
                           vecs[i].stop, vecs[i].snz);
            check_output(vecs[i].name, vecs[i].exp_alarm, vecs[i].exp_state, vecs[i].exp_cnt);
        end

        // Auto-stop after 5 ticks of 10 cycles, with a set-time edit mid-ring.
        step("a_arm",        0, 8'h07, 8'h30, 8'h00, 1, 0, 0, 0, 2'b01, 4'd0);
        step("a_clear",      1, 8'h07, 8'h34, 8'h00, 1, 0, 0, 0, 2'b01, 4'd0);
        step("a_trigger",    1, 8'h07, 8'h30, 8'h00, 1, 0, 0, 1, 2'b10, 4'd0);
        idle(9);
        set_min = 8'h45;
        idle(40);
        check_output("a_ring_49", 1'b1, 2'b10, 4'd0);
        idle(1);
        check_output("a_auto_stop", 1'b0, 2'b01, 4'd0);
        set_min = 8'h30;
        step("a_no_retrig",  1, 8'h07, 8'h30, 8'h00, 1, 0, 0, 0, 2'b01, 4'd0);
        step("a_min31",      1, 8'h07, 8'h31, 8'h00, 1, 0, 0, 0, 2'b01, 4'd0);
        step("a_next_day",   1, 8'h07, 8'h30, 8'h00, 1, 0, 0, 1, 2'b10, 4'd0);

        // Snooze limit: two snoozes of 30 cycles each, the third dismisses.
        step("b_snooze1",    0, 8'h07, 8'h30, 8'h00, 1, 0, 1, 0, 2'b11, 4'd1);
        idle(29);
        check_output("b_snz_29", 1'b0, 2'b11, 4'd1);
        idle(1);
        check_output("b_rering1", 1'b1, 2'b10, 4'd1);
        step("b_snooze2",    0, 8'h07, 8'h30, 8'h00, 1, 0, 1, 0, 2'b11, 4'd2);
        idle(30);
        check_output("b_rering2", 1'b1, 2'b10, 4'd2);
        step("b_snooze3",    0, 8'h07, 8'h30, 8'h00, 1, 0, 1, 0, 2'b01, 4'd2);

        // Coincident buttons with a non-zero snooze count, then disarm.
        step("c_clear",      1, 8'h07, 8'h35, 8'h00, 1, 0, 0, 0, 2'b01, 4'd2);
        step("c_trigger",    1, 8'h07, 8'h30, 8'h00, 1, 0, 0, 1, 2'b10, 4'd0);
        step("c_snooze",     0, 8'h07, 8'h30, 8'h00, 1, 0, 1, 0, 2'b11, 4'd1);
        idle(30);
        check_output("c_rering", 1'b1, 2'b10, 4'd1);
        step("c_stop_snz",   0, 8'h07, 8'h30, 8'h00, 1, 1, 1, 0, 2'b01, 4'd1);
        step("c_disarm",     0, 8'h07, 8'h30, 8'h00, 0, 0, 0, 0, 2'b00, 4'd1);

        // Asynchronous reset while ringing, checked before any further clock edge.
        step("d_arm",        0, 8'h07, 8'h30, 8'h00, 1, 0, 0, 0, 2'b01, 4'd1);
        step("d_clear",      1, 8'h07, 8'h36, 8'h00, 1, 0, 0, 0, 2'b01, 4'd1);
        step("d_trigger",    1, 8'h07, 8'h30, 8'h00, 1, 0, 0, 1, 2'b10, 4'd0);
        #2;
        reset_p = 1'b1;
        #1;
        check_output("d_async_reset", 1'b0, 2'b00, 4'd0);
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        step("d_match_off",  1, 8'h07, 8'h30, 8'h00, 0, 0, 0, 0, 2'b00, 4'd0);
        step("d_rearm",      0, 8'h07, 8'h30, 8'h00, 1, 0, 0, 0, 2'b01, 4'd0);
        step("d_trigger2",   1, 8'h07, 8'h30, 8'h00, 1, 0, 0, 1, 2'b10, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
